seq_mul8_tiler: RTL and testbench

SEQ_MUL8_TILER -- requirements
Module: seq_mul8_tiler

---
 rtl/seq_mul8_tiler_pkg.sv | 29 ++
 rtl/seq_mul8_tiler_mul2x2_exact.sv | 12 +
 rtl/seq_mul8_tiler.sv | 108 ++++++++++
 tb/tb_seq_mul8_tiler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul8_tiler_pkg.sv
// Shared types and sizing for the 8x8 sequential multiplier built from an
// external 2x2 tile.
package seq_mul8_tiler_pkg;

    localparam int DIGIT_W = 2;
    localparam int OP_W    = 8;
    localparam int NDIG    = 4;
    localparam int STEPS   = 16;
    localparam int ACC_W   = 17;
    localparam int STEP_W  = 4;
    localparam int ERR_W   = 5;

    localparam logic [STEP_W-1:0] LAST_STEP = 4'(STEPS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit weight of the partial product for step s: 2*(i+j), i=s[3:2], j=s[1:0].
    function automatic logic [STEP_W-1:0] digit_shift(input logic [STEP_W-1:0] s);
        logic [STEP_W-1:0] sh;
        sh = ({2'b00, s[3:2]} + {2'b00, s[1:0]}) << 1;
        return sh;
    endfunction

endpackage

// File: rtl/seq_mul8_tiler_mul2x2_exact.sv
// Golden combinational 2x2 multiplier, used only to judge the external tile.
module mul2x2_exact
    import seq_mul8_tiler_pkg::*;
(
    input  logic [DIGIT_W-1:0]   x,
    input  logic [DIGIT_W-1:0]   y,
    output logic [2*DIGIT_W-1:0] prod
);

    assign prod = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/seq_mul8_tiler.sv
// 8x8 multiplier that walks all 16 digit pairs through an external 2x2 tile,
// accumulating shifted partial products and counting tile mistakes.
module seq_mul8_tiler
    import seq_mul8_tiler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_W-1:0]      a,
    input  logic [OP_W-1:0]      b,
    output logic [DIGIT_W-1:0]   tile_a,
    output logic [DIGIT_W-1:0]   tile_b,
    input  logic [2*DIGIT_W-1:0] tile_p,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          p,
    output logic                 ovf,
    output logic [ERR_W-1:0]     err_cnt
);

    state_t                 state_reg;
    logic [OP_W-1:0]        a_reg;
    logic [OP_W-1:0]        b_reg;
    logic [STEP_W-1:0]      s_reg;
    logic [ACC_W-1:0]       acc_reg;
    logic [ACC_W-1:0]       acc_next;
    logic [ERR_W-1:0]       err_reg;
    logic [ERR_W-1:0]       err_next;
    logic [2*DIGIT_W-1:0]   gold_p;

    logic [DIGIT_W-1:0]     a_dig [NDIG];
    logic [DIGIT_W-1:0]     b_dig [NDIG];

    // Split the latched operands into radix-4 digits.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digits
            assign a_dig[gi] = a_reg[gi*DIGIT_W +: DIGIT_W];
            assign b_dig[gi] = b_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // Digits go to the tile only while running; otherwise the tile sees zeros.
    assign tile_a = (state_reg == RUN) ? a_dig[s_reg[3:2]] : '0;
    assign tile_b = (state_reg == RUN) ? b_dig[s_reg[1:0]] : '0;

    mul2x2_exact u_gold (
        .x    (tile_a),
        .y    (tile_b),
        .prod (gold_p)
    );

    // Next accumulator and saturating error count for the current step.
    always_comb begin
        acc_next = acc_reg + (ACC_W'(tile_p) << digit_shift(s_reg));
        err_next = err_reg;
        if ((tile_p != gold_p) && (err_reg < ERR_MAX)) begin
            err_next = err_reg + 5'd1;
        end
    end

    // Control FSM with operand latching, accumulation and step counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            acc_reg   <= '0;
            err_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        s_reg     <= '0;
                        acc_reg   <= '0;
                        err_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    err_reg <= err_next;
                    s_reg   <= s_reg + 4'd1;
                    if (s_reg == LAST_STEP) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Results are read straight from the accumulator, which only moves in RUN
    // and is cleared on an accepted start, so they hold across IDLE.
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign p       = acc_reg[15:0];
    assign ovf     = acc_reg[16];
    assign err_cnt = err_reg;

endmodule

// File: tb/tb_seq_mul8_tiler.sv
// Scoreboard bench for seq_mul8_tiler with a behavioural tile and reference model.
module tb_seq_mul8_tiler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] tile_a;
    logic [1:0] tile_b;
    logic [3:0] tile_p;
    logic       busy;
    logic       done;
    logic [15:0] p;
    logic       ovf;
    logic [4:0] err_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tile_mode = 0;
    logic rst_at_edge = 1'b0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          issue;
        logic [15:0] p;
        logic        ovf;
        logic [4:0]  err;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    seq_mul8_tiler dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .tile_a  (tile_a),
        .tile_b  (tile_b),
        .tile_p  (tile_p),
        .busy    (busy),
        .done    (done),
        .p       (p),
        .ovf     (ovf),
        .err_cnt (err_cnt)
    );

    // Tile variants: 0 exact, 1 stuck at 15, 2 wrong 3*3 (=1), 3 "wrong" 3*3 (=9, i.e. exact).
    function automatic int tile_fn(input int mode, input int x, input int y);
        case (mode)
            1:       return 15;
            2:       return (x == 3 && y == 3) ? 1 : x * y;
            3:       return (x == 3 && y == 3) ? 9 : x * y;
            default: return x * y;
        endcase
    endfunction

    function automatic int digit(input logic [7:0] v, input int k);
        return (int'(v) >> (2 * k)) & 3;
    endfunction

    always_comb tile_p = 4'(tile_fn(tile_mode, int'(tile_a), int'(tile_b)));

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Sum of all digit-pair tile products at their weights, plus mistake count.
    function automatic exp_t ref_model(input logic [7:0] ia, input logic [7:0] ib,
                                       input int mode, input int issue_edge);
        exp_t e;
        int sum;
        int errs;
        int x;
        int y;
        int t;
        sum  = 0;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                x = digit(ia, i);
                y = digit(ib, j);
                t = tile_fn(mode, x, y);
                sum += t * (1 << (2 * (i + j)));
                if (t != x * y) errs++;
            end
        end
        e.a     = ia;
        e.b     = ib;
        e.issue = issue_edge;
        e.p     = 16'(sum % 65536);
        e.ovf   = (sum >= 65536);
        e.err   = 5'((errs > 16) ? 16 : errs);
        return e;
    endfunction

    // Monitor: per-cycle busy/done/tile digits, and results on the expected done cycle.
    always @(negedge clk) begin
        logic       exp_busy;
        logic       exp_done;
        logic [1:0] ea;
        logic [1:0] eb;
        int         s;
        exp_t       e;
        if (rst_at_edge) sbq.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        ea = 2'd0;
        eb = 2'd0;
        if (sbq.size() > 0) begin
            e = sbq[0];
            s = cyc - e.issue;
            exp_busy = (s >= 0 && s <= 16);
            exp_done = (s == 16);
            if (s >= 0 && s <= 15) begin
                ea = 2'(digit(e.a, s / 4));
                eb = 2'(digit(e.b, s % 4));
            end
        end
        check("busy_done_tile", {26'd0, busy, done, tile_a, tile_b},
              {26'd0, exp_busy, exp_done, ea, eb});
        if (exp_done) begin
            $display("op a=%0d b=%0d mode=%0d: p=0x%0h ovf=%0d err_cnt=%0d (exp 0x%0h %0d %0d)",
                     e.a, e.b, tile_mode, p, ovf, err_cnt, e.p, e.ovf, e.err);
            check("result_p", 32'(p), 32'(e.p));
            check("result_ovf", 32'(ovf), 32'(e.ovf));
            check("result_err_cnt", 32'(err_cnt), 32'(e.err));
            void'(sbq.pop_front());
        end
    end

    // Drive an accepted start at the current negedge; returns one cycle later.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, output exp_t e);
        e = ref_model(ia, ib, tile_mode, cyc + 1);
        sbq.push_back(e);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input int mode);
        exp_t e;
        @(negedge clk);
        tile_mode = mode;
        issue(ia, ib, e);
        wait_done();
        repeat (2) @(negedge clk);
        check("hold_p", 32'(p), 32'(e.p));
        check("hold_err_cnt", 32'(err_cnt), 32'(e.err));
    endtask

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {13'd0, busy, done, p, ovf, err_cnt},
              {13'd0, 1'b0, 1'b0, 16'd0, 1'b0, 5'd0});
        rst = 1'b0;

        run_op(8'd255, 8'd255, 0);
        run_op(8'd0,   8'd173, 0);
        run_op(8'd255, 8'd255, 1);
        run_op(8'd255, 8'd255, 2);
        run_op(8'd3,   8'd255, 2);
        run_op(8'd255, 8'd255, 3);

        // Start during RUN is ignored; start during DONE is ignored; next IDLE start accepted.
        @(negedge clk);
        tile_mode = 0;
        issue(8'd12, 8'd34, e);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 8'd99;
        b     = 8'd99;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        a     = 8'd17;
        b     = 8'd5;
        @(negedge clk);
        issue(8'd200, 8'd150, e);
        wait_done();

        // Reset in the 8th RUN cycle, with start held, aborts the operation.
        repeat (2) @(negedge clk);
        issue(8'd77, 8'd88, e);
        repeat (7) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("abort_outputs", {15'd0, busy, p, ovf, err_cnt},
              {15'd0, 1'b0, 16'd0, 1'b0, 5'd0});
        run_op(8'd7, 8'd9, 0);

        for (int n = 0; n < 20; n++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
